alarm_display_ctrl: RTL

//   Frame-synchronous intrusion-alarm sequencer that drives the video-on select of the VGA overlay.
//   - Qualifies ADC sensor samples against a threshold over consecutive frames.
//   - Walks a DISARMED/ARMED/ALARM/LOCKOUT state machine.
//   - Produces oVideo_On, a blink strobe and an alarm event count.
//   - Changes state and outputs only at frame start, so the overlay never switches mid-frame.

---
 rtl/alarm_display_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/alarm_display_ctrl.sv
// Frame-synchronous intrusion-alarm sequencer driving the VGA overlay video-on select.
// Sensor samples are qualified per frame. The DISARMED/ARMED/ALARM/LOCKOUT machine and all
// outputs change only on frame-start cycles, so the overlay never switches mid-frame.
module alarm_display_ctrl #(
    parameter int unsigned SAMPLE_W       = 12,
    parameter int unsigned TRIP_FRAMES    = 3,
    parameter int unsigned HOLD_FRAMES    = 300,
    parameter int unsigned LOCKOUT_FRAMES = 120,
    parameter int unsigned BLINK_FRAMES   = 30
) (
    input  logic                iCLK,
    input  logic                iRST_N,
    input  logic                iFrame_Start,
    input  logic                iSample_Valid,
    input  logic [SAMPLE_W-1:0] iSample,
    input  logic [SAMPLE_W-1:0] iThreshold,
    input  logic                iArm,
    input  logic                iAck,
    output logic                oVideo_On,
    output logic                oBlink,
    output logic [1:0]          oState,
    output logic [7:0]          oAlarm_Cnt
);

    localparam int unsigned TripW  = $clog2(TRIP_FRAMES + 1);
    localparam int unsigned HoldW  = $clog2(HOLD_FRAMES + 1);
    localparam int unsigned LockW  = $clog2(LOCKOUT_FRAMES + 1);
    localparam int unsigned BlinkW = $clog2(BLINK_FRAMES + 1);

    typedef enum logic [1:0] {
        StDisarmed = 2'd0,
        StArmed    = 2'd1,
        StAlarm    = 2'd2,
        StLockout  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic               above_q, above_d;
    logic               ack_q, ack_d;
    logic [TripW-1:0]   trip_q, trip_d;
    logic [HoldW-1:0]   hold_q, hold_d;
    logic [LockW-1:0]   lock_q, lock_d;
    logic [BlinkW-1:0]  blink_cnt_q, blink_cnt_d;
    logic               blink_q, blink_d;
    logic               video_q, video_d;
    logic [7:0]         alarm_cnt_q, alarm_cnt_d;
    logic               sample_above;

    assign sample_above = iSample_Valid && (iSample >= iThreshold);

    // Next-state: sticky flags, frame-start transitions and counter updates.
    always_comb begin
        state_d     = state_q;
        above_d     = above_q;
        ack_d       = ack_q;
        trip_d      = trip_q;
        hold_d      = hold_q;
        lock_d      = lock_q;
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;
        alarm_cnt_d = alarm_cnt_q;

        if (iFrame_Start) begin
            // Sticky flags describe the frame just ended; clear them for the new one.
            above_d = 1'b0;
            ack_d   = 1'b0;

            if (!iArm) begin
                state_d = StDisarmed;
            end else begin
                unique case (state_q)
                    StDisarmed: state_d = StArmed;
                    StArmed: begin
                        if (above_q && (32'(trip_q) + 32'd1 >= TRIP_FRAMES)) begin
                            state_d     = StAlarm;
                            hold_d      = HoldW'(HOLD_FRAMES);
                            blink_cnt_d = '0;
                            blink_d     = 1'b1;
                            if (alarm_cnt_q != 8'hFF) begin
                                alarm_cnt_d = alarm_cnt_q + 8'd1;
                            end
                        end
                    end
                    StAlarm: begin
                        if (ack_q) begin
                            state_d = StLockout;
                            lock_d  = LockW'(LOCKOUT_FRAMES);
                        end else if (above_q) begin
                            hold_d = HoldW'(HOLD_FRAMES);
                        end else if (hold_q <= HoldW'(1)) begin
                            hold_d  = '0;
                            state_d = StLockout;
                            lock_d  = LockW'(LOCKOUT_FRAMES);
                        end else begin
                            hold_d = hold_q - HoldW'(1);
                        end
                    end
                    StLockout: begin
                        if (lock_q <= LockW'(1)) begin
                            lock_d  = '0;
                            state_d = StArmed;
                        end else begin
                            lock_d = lock_q - LockW'(1);
                        end
                    end
                    default: state_d = StDisarmed;
                endcase
            end

            // Blink phase advances only on frames that stay in ALARM.
            if (state_q == StAlarm && state_d == StAlarm) begin
                if (32'(blink_cnt_q) + 32'd1 >= BLINK_FRAMES) begin
                    blink_cnt_d = '0;
                    blink_d     = ~blink_q;
                end else begin
                    blink_cnt_d = blink_cnt_q + BlinkW'(1);
                end
            end
            if (state_d != StAlarm) begin
                blink_d     = 1'b0;
                blink_cnt_d = '0;
            end

            // Consecutive-frame qualification only runs while remaining ARMED.
            if (state_q == StArmed && state_d == StArmed) begin
                if (!above_q) begin
                    trip_d = '0;
                end else if (32'(trip_q) < TRIP_FRAMES) begin
                    trip_d = trip_q + TripW'(1);
                end
            end else begin
                trip_d = '0;
            end
        end

        // Events in the frame-start cycle belong to the new frame.
        if (sample_above) begin
            above_d = 1'b1;
        end
        if (iAck && state_q == StAlarm) begin
            ack_d = 1'b1;
        end
    end

    // Registered video select follows the state being entered.
    always_comb begin
        video_d = (state_d == StAlarm);
    end

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state_q     <= StDisarmed;
            above_q     <= 1'b0;
            ack_q       <= 1'b0;
            trip_q      <= '0;
            hold_q      <= '0;
            lock_q      <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
            video_q     <= 1'b0;
            alarm_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            above_q     <= above_d;
            ack_q       <= ack_d;
            trip_q      <= trip_d;
            hold_q      <= hold_d;
            lock_q      <= lock_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            video_q     <= video_d;
            alarm_cnt_q <= alarm_cnt_d;
        end
    end

    assign oVideo_On  = video_q;
    assign oBlink     = blink_q;
    assign oState     = state_q;
    assign oAlarm_Cnt = alarm_cnt_q;

endmodule
